// File: rtl/render_pkg.sv
// -----------------------------------------------------------------------------
// render_pkg
// Shared constants for the frame renderer: screen geometry, the palette and
// the frame FSM state type.
// Optional feature macro used by the renderer: FRAME_RENDERER_HUD_EN.
// -----------------------------------------------------------------------------
package render_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int NPIX     = SCREEN_W * SCREEN_H;

   localparam logic [2:0] COL_BG     = 3'b000;
   localparam logic [2:0] COL_USER   = 3'b010;
   localparam logic [2:0] COL_ENEMY  = 3'b100;
   localparam logic [2:0] COL_BULLET = 3'b111;
   localparam logic [2:0] COL_HUD    = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SNAP = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// x/y raster position counter, x fastest, 0..159 by 0..119.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : synchronous clear to (0,0), wins over i_en
//   i_en           : advance one pixel
//   o_x, o_y       : current position
//   o_last         : high while the position is (159,119)
// -----------------------------------------------------------------------------
module raster_counter
   import render_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clr,
   input  logic       i_en,
   output logic [7:0] o_x,
   output logic [6:0] o_y,
   output logic       o_last
);

   logic [7:0] r_x;
   logic [6:0] r_y;
   logic       w_x_end;
   logic       w_y_end;

   assign w_x_end = (r_x == 8'(SCREEN_W - 1));
   assign w_y_end = (r_y == 7'(SCREEN_H - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (i_en) begin
         if (w_x_end) begin
            r_x <= '0;
            r_y <= w_y_end ? 7'd0 : r_y + 7'd1;
         end else begin
            r_x <= r_x + 8'd1;
         end
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/frame_renderer.sv
// -----------------------------------------------------------------------------
// frame_renderer
// Walks the 160x120 screen once per drawEn, one pixel per clock, and plots
// each pixel with the colour of the highest-priority object covering it:
// HUD bar (optional) > user ship > enemy ship > bullet > background.
// Ship positions (and health) are snapshotted at frame start; grid is live.
//
// Optional feature: define FRAME_RENDERER_HUD_EN to draw a health bar in
// rows 0-1 (x < 4*health yellow, rest black). Without it ship_health is unused.
//
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   drawEn               : start one frame (ignored while busy)
//   user_x/y, enemy_x/y  : ship top-left positions
//   grid                 : bullet bitmap, bit y*160+x
//   ship_health          : health for the HUD bar
//   vga_x/y/colour/plot  : registered pixel stream to the VGA adapter
//   busy                 : frame in progress
//   frame_done           : one-cycle pulse after the last pixel
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for drawEn
// SNAP    | latch positions/health, clear raster counter
// SCAN    | one pixel per clock, (0,0) .. (159,119)
// DONE    | last pixel in output stage; pulse frame_done
// -----------------------------------------------------------------------------
module frame_renderer
   import render_pkg::*;
#(
   parameter int SHIP_W = 8,
   parameter int SHIP_H = 4
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            drawEn,
   input  logic [7:0]      user_x,
   input  logic [6:0]      user_y,
   input  logic [7:0]      enemy_x,
   input  logic [6:0]      enemy_y,
   input  logic [NPIX-1:0] grid,
   input  logic [3:0]      ship_health,
   output logic [7:0]      vga_x,
   output logic [6:0]      vga_y,
   output logic [2:0]      vga_colour,
   output logic            vga_plot,
   output logic            busy,
   output logic            frame_done
);

   state_t      r_state;
   logic        r_busy;
   logic        r_frame_done;
   logic [7:0]  r_ux;
   logic [6:0]  r_uy;
   logic [7:0]  r_ex;
   logic [6:0]  r_ey;

   logic [7:0]  r_vx;
   logic [6:0]  r_vy;
   logic [2:0]  r_col;
   logic        r_plot;

   logic [7:0]  w_x;
   logic [6:0]  w_y;
   logic        w_last;
   logic        w_clr;
   logic        w_en;

   assign w_clr = (r_state == ST_SNAP);
   assign w_en  = (r_state == ST_SCAN);

   raster_counter u_raster (
      .i_clk   (clk),
      .i_rst_n (resetn),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .o_x     (w_x),
      .o_y     (w_y),
      .o_last  (w_last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
         r_ux         <= '0;
         r_uy         <= '0;
         r_ex         <= '0;
         r_ey         <= '0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (drawEn) begin
                  r_state <= ST_SNAP;
                  r_busy  <= 1'b1;
               end
            end
            ST_SNAP: begin
               r_ux    <= user_x;
               r_uy    <= user_y;
               r_ex    <= enemy_x;
               r_ey    <= enemy_y;
               r_state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (w_last) r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state      <= ST_IDLE;
               r_busy       <= 1'b0;
               r_frame_done <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Hit tests widened by one bit so sx+SHIP_W cannot wrap back on-screen.
   logic [8:0]  w_x9;
   logic [7:0]  w_y8;
   logic        w_user_hit;
   logic        w_enemy_hit;
   logic [14:0] w_grid_idx;
   logic        w_bullet;
   logic [2:0]  w_colour;

   assign w_x9 = {1'b0, w_x};
   assign w_y8 = {1'b0, w_y};

   assign w_user_hit  = (w_x9 >= {1'b0, r_ux}) && (w_x9 < {1'b0, r_ux} + 9'(SHIP_W)) &&
                        (w_y8 >= {1'b0, r_uy}) && (w_y8 < {1'b0, r_uy} + 8'(SHIP_H));
   assign w_enemy_hit = (w_x9 >= {1'b0, r_ex}) && (w_x9 < {1'b0, r_ex} + 9'(SHIP_W)) &&
                        (w_y8 >= {1'b0, r_ey}) && (w_y8 < {1'b0, r_ey} + 8'(SHIP_H));

   assign w_grid_idx = 15'(w_y) * 15'(SCREEN_W) + 15'(w_x);
   assign w_bullet   = grid[w_grid_idx];

`ifdef FRAME_RENDERER_HUD_EN
   logic [3:0] r_hp;
   logic       w_hud_row;
   logic       w_hud_on;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                r_hp <= '0;
      else if (r_state == ST_SNAP) r_hp <= ship_health;
   end

   assign w_hud_row = (w_y < 7'd2);
   assign w_hud_on  = (w_x9 < {3'b000, r_hp, 2'b00});
`else
   logic w_unused_health;
   assign w_unused_health = ^ship_health;
`endif

   always_comb begin
      w_colour = COL_BG;
      if (w_user_hit)       w_colour = COL_USER;
      else if (w_enemy_hit) w_colour = COL_ENEMY;
      else if (w_bullet)    w_colour = COL_BULLET;
`ifdef FRAME_RENDERER_HUD_EN
      if (w_hud_row) w_colour = w_hud_on ? COL_HUD : COL_BG;
`endif
   end

   // One output stage; position/colour hold their last value outside SCAN.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_vx   <= '0;
         r_vy   <= '0;
         r_col  <= '0;
         r_plot <= 1'b0;
      end else begin
         r_plot <= w_en;
         if (w_en) begin
            r_vx  <= w_x;
            r_vy  <= w_y;
            r_col <= w_colour;
         end
      end
   end

   assign vga_x      = r_vx;
   assign vga_y      = r_vy;
   assign vga_colour = r_col;
   assign vga_plot   = r_plot;
   assign busy       = r_busy;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_frame_renderer.sv
// -----------------------------------------------------------------------------
// tb_frame_renderer
// Self-checking bench: every plotted pixel is compared with a behavioural
// model that computes the colour straight from the object rectangles, the
// bullet bitmap and the priority order. Frame timing is checked against the
// cycle offsets from drawEn. Honours FRAME_RENDERER_HUD_EN like the design.
// -----------------------------------------------------------------------------
module tb_frame_renderer;

   localparam int SW     = 160;
   localparam int SH     = 120;
   localparam int NPIX   = SW * SH;
   localparam int SHIP_W = 8;
   localparam int SHIP_H = 4;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic            drawEn = 1'b0;
   logic [7:0]      user_x = '0;
   logic [6:0]      user_y = '0;
   logic [7:0]      enemy_x = '0;
   logic [6:0]      enemy_y = '0;
   logic [NPIX-1:0] grid = '0;
   logic [3:0]      ship_health = '0;
   logic [7:0]      vga_x;
   logic [6:0]      vga_y;
   logic [2:0]      vga_colour;
   logic            vga_plot;
   logic            busy;
   logic            frame_done;

   frame_renderer #(.SHIP_W(SHIP_W), .SHIP_H(SHIP_H)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .drawEn      (drawEn),
      .user_x      (user_x),
      .user_y      (user_y),
      .enemy_x     (enemy_x),
      .enemy_y     (enemy_y),
      .grid        (grid),
      .ship_health (ship_health),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int k = 0;
   int pix_idx = 0;
   int m_ux, m_uy, m_ex, m_ey, m_hp;
   logic [2:0] fb [NPIX];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_colour(input int x, input int y);
`ifdef FRAME_RENDERER_HUD_EN
      if (y < 2) return (x < 4 * m_hp) ? 6 : 0;
`endif
      if (x >= m_ux && x < m_ux + SHIP_W && y >= m_uy && y < m_uy + SHIP_H) return 2;
      if (x >= m_ex && x < m_ex + SHIP_W && y >= m_ey && y < m_ey + SHIP_H) return 4;
      if (grid[y * SW + x]) return 7;
      return 0;
   endfunction

   // Advance one clock and compare any plotted pixel with the model.
   task automatic tick();
      int ex, ey, ec;
      @(negedge clk);
      k++;
      if (vga_plot) begin
         if (pix_idx >= NPIX) begin
            check("extra_plot", pix_idx, NPIX - 1);
         end else begin
            ex = pix_idx % SW;
            ey = pix_idx / SW;
            ec = model_colour(ex, ey);
            checks++;
            if (int'(vga_x) != ex || int'(vga_y) != ey || int'(vga_colour) != ec) begin
               errors++;
               $display("FAIL pixel#%0d actual=(%0d,%0d,c%0d) required=(%0d,%0d,c%0d)",
                        pix_idx, vga_x, vga_y, vga_colour, ex, ey, ec);
            end
            fb[pix_idx] = vga_colour;
         end
         pix_idx++;
      end
   endtask

   // Run one frame. mid_k: at that cycle move user_x to 5 and hold drawEn
   // high for a few cycles. abort_px: assert reset once that many pixels plotted.
   task automatic run_frame(input int mid_k, input int abort_px);
      int first_k, last_k, done_k, done_cnt;
      m_ux = user_x; m_uy = user_y; m_ex = enemy_x; m_ey = enemy_y; m_hp = ship_health;
      pix_idx = 0; first_k = -1; last_k = -1; done_k = -1; done_cnt = 0;
      k = 0;
      drawEn = 1'b1;
      tick();
      drawEn = 1'b0;
      check("busy_T1", busy, 1);
      check("plot_T1", vga_plot, 0);
      while (k < 19260) begin
         tick();
         if (mid_k != 0 && k == mid_k)     begin user_x = 8'd5; drawEn = 1'b1; end
         if (mid_k != 0 && k == mid_k + 5) drawEn = 1'b0;
         if (vga_plot) begin
            if (first_k < 0) first_k = k;
            last_k = k;
         end
         if (frame_done) begin
            done_cnt++;
            if (done_k < 0) begin
               done_k = k;
               check("busy_at_done", busy, 0);
            end
         end
         if (abort_px != 0 && pix_idx == abort_px) begin
            resetn = 1'b0;
            #1;
            check("abort_plot", vga_plot, 0);
            check("abort_busy", busy, 0);
            check("abort_done", frame_done, 0);
            repeat (20) begin
               tick();
               if (frame_done) done_cnt++;
            end
            check("abort_no_done", done_cnt, 0);
            check("abort_pixels", pix_idx, abort_px);
            resetn = 1'b1;
            tick();
            return;
         end
         if (done_k >= 0 && k > done_k + 2 && !busy) break;
      end
      check("first_plot_k", first_k, 3);
      check("last_plot_k", last_k, 19202);
      check("frame_done_k", done_k, 19203);
      check("frame_done_cnt", done_cnt, 1);
      check("plot_count", pix_idx, NPIX);
   endtask

   initial begin
      // Reset state
      repeat (2) tick();
      check("rst_vga_x", vga_x, 0);
      check("rst_vga_y", vga_y, 0);
      check("rst_colour", vga_colour, 0);
      check("rst_plot", vga_plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", frame_done, 0);
      resetn = 1'b1;
      repeat (3) tick();

      // F1: ships at (0,0) and (100,50), single bullet at (30,20)
      user_x = 8'd0;   user_y = 7'd0;
      enemy_x = 8'd100; enemy_y = 7'd50;
      ship_health = 4'd4;
      grid[20 * SW + 30] = 1'b1;
      run_frame(0, 0);
      check("f1_px7_3", fb[3 * SW + 7], 2);
      check("f1_px8_3", fb[3 * SW + 8], 0);
      check("f1_px0_4", fb[4 * SW + 0], 0);
      check("f1_px100_50", fb[50 * SW + 100], 4);
      check("f1_px107_53", fb[53 * SW + 107], 4);
      check("f1_px108_53", fb[53 * SW + 108], 0);
      check("f1_px30_20", fb[20 * SW + 30], 7);
`ifdef FRAME_RENDERER_HUD_EN
      check("f1_hud15_1", fb[1 * SW + 15], 6);
      check("f1_hud16_1", fb[1 * SW + 16], 0);
      check("f1_px0_2", fb[2 * SW + 0], 2);
`else
      check("f1_px0_0", fb[0], 2);
      check("f1_px15_1", fb[1 * SW + 15], 0);
`endif
      repeat (2) tick();

      // F2: user ship covers the bullet
      user_x = 8'd28; user_y = 7'd18;
      enemy_x = 8'($urandom_range(40, 255)); enemy_y = 7'($urandom_range(30, 127));
      run_frame(0, 0);
      check("f2_px30_20", fb[20 * SW + 30], 2);
      repeat (2) tick();

      // F3: corner clipping, mid-frame move and ignored drawEn
      user_x = 8'd156; user_y = 7'd118;
      enemy_x = 8'd60; enemy_y = 7'd10;
      run_frame(8000, 0);
      check("f3_px156_118", fb[118 * SW + 156], 2);
      check("f3_px159_119", fb[119 * SW + 159], 2);
      check("f3_px155_118", fb[118 * SW + 155], 0);
      check("f3_px0_119", fb[119 * SW + 0], 0);
      check("f3_px3_118", fb[118 * SW + 3], 0);
      check("f3_px5_118", fb[118 * SW + 5], 0);
      repeat (2) tick();

      // F4: random scene, reset at pixel 5000
      for (int i = 0; i < 300; i++) grid[$urandom_range(0, NPIX - 1)] = 1'b1;
      user_x = 8'($urandom_range(0, 255)); user_y = 7'($urandom_range(0, 127));
      enemy_x = 8'($urandom_range(0, 255)); enemy_y = 7'($urandom_range(0, 127));
      ship_health = 4'($urandom_range(0, 15));
      run_frame(0, 5000);
      repeat (2) tick();

      // F5: random scene after the abort restarts from (0,0)
      for (int i = 0; i < 300; i++) grid[$urandom_range(0, NPIX - 1)] = 1'b1;
      user_x = 8'($urandom_range(0, 159)); user_y = 7'($urandom_range(0, 119));
      enemy_x = 8'($urandom_range(0, 255)); enemy_y = 7'($urandom_range(0, 127));
      ship_health = 4'($urandom_range(0, 15));
      run_frame(0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
